x_23k640_slave: RTL and testbench

Behavioural-RTL responder for the 23K640 SPI SRAM. It sits on the far side of the SPI pins, opposite the 23K640 master controller, and emulates the device. It decodes the WRSR, RDSR, READ and WRITE instructions and supports byte, page and sequential modes. A 2^ADDR_W-byte array is backed by a single sub-module. The block is synthesisable so the master can be closed-loop tested in simulation and on FPGA without a physical part.

---
 rtl/x_23k640_slave_pkg.sv | 29 ++
 rtl/x_23k640_slave_mem.sv | 27 ++
 rtl/x_23k640_slave.sv | 255 +++++++++++++++++++++++++
 tb/tb_x_23k640_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_23k640_slave_pkg.sv
// Opcodes, mode encodings and FSM states shared by the 23K640 SPI SRAM responder.
package x_23K640_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_SR_WR = 3'd5,
        ST_SR_RD = 3'd6,
        ST_DONE  = 3'd7
    } slave_state_e;

    // Mode 11 is reserved and behaves like byte mode.
    function automatic logic is_byte_mode(input logic [1:0] mode);
        return (mode == MODE_BYTE) || (mode == 2'b11);
    endfunction

endpackage

// File: rtl/x_23k640_slave_mem.sv
// Byte array behind the 23K640 responder: async read, sync write, async backdoor read.
module x_23K640_slave_mem #(
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata,
    input  logic [ADDR_W-1:0] i_bd_addr,
    output logic [7:0]        o_bd_rdata
);

    logic [7:0] mem_r [2**ADDR_W];

    // Synchronous write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata    = mem_r[i_raddr];
    assign o_bd_rdata = mem_r[i_bd_addr];

endmodule

// File: rtl/x_23k640_slave.sv
// 23K640 SPI SRAM device emulator: decodes WRSR/RDSR/READ/WRITE over mode-0 SPI,
// oversampling SCK in the i_clk domain.
module x_23k640_slave
    import x_23K640_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int PAGE_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cs,
    input  logic              i_sck,
    input  logic              i_si,
    output logic              o_so,
    output logic              o_so_en,
    output logic [7:0]        o_status,
    output logic              o_err,
    input  logic [ADDR_W-1:0] i_bd_addr,
    output logic [7:0]        o_bd_rdata
);

    slave_state_e      state_r, state_nxt_s;
    logic [4:0]        bit_cnt_r, cnt_nxt_s;
    logic              sck_q_r;
    logic [15:0]       rx_r;
    logic [6:0]        tx_r;
    logic [ADDR_W-1:0] addr_r;
    logic              is_read_r;
    logic              byte_sent_r;
    logic [7:0]        status_r;
    logic              so_r, so_en_r, err_r;

    logic              rise_s, fall_s;
    logic [15:0]       rx_shift_s;
    logic [7:0]        mem_rdata_s;
    logic              byte_mode_s;
    logic              mem_we_s, addr_ld_s, addr_adv_s, status_ld_s, op_ld_s, err_s;
    logic              load_mem_s, load_sr_s, shift_s, stop_s;
    logic              unused_s;

    assign rise_s      = i_sck & ~sck_q_r & ~i_cs;
    assign fall_s      = ~i_sck & sck_q_r & ~i_cs;
    assign rx_shift_s  = {rx_r[14:0], i_si};
    assign byte_mode_s = is_byte_mode(status_r[7:6]);
    assign unused_s    = ^{rx_r[15], rx_shift_s[15:ADDR_W]};

    // Page mode wraps inside the current page; everything else wraps the whole array.
    function automatic logic [ADDR_W-1:0] addr_adv(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] mode);
        logic [ADDR_W-1:0] inc;
        inc = a + ADDR_W'(1);
        if (mode == MODE_PAGE) begin
            return {a[ADDR_W-1:PAGE_W], inc[PAGE_W-1:0]};
        end else begin
            return inc;
        end
    endfunction

    x_23K640_slave_mem #(.ADDR_W(ADDR_W)) u_mem (
        .i_clk      (i_clk),
        .i_we       (mem_we_s),
        .i_waddr    (addr_r),
        .i_wdata    (rx_shift_s[7:0]),
        .i_raddr    (addr_r),
        .o_rdata    (mem_rdata_s),
        .i_bd_addr  (i_bd_addr),
        .o_bd_rdata (o_bd_rdata)
    );

    // FSM state and phase bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 5'd0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= cnt_nxt_s;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = bit_cnt_r;
        mem_we_s    = 1'b0;
        addr_ld_s   = 1'b0;
        addr_adv_s  = 1'b0;
        status_ld_s = 1'b0;
        op_ld_s     = 1'b0;
        err_s       = 1'b0;
        load_mem_s  = 1'b0;
        load_sr_s   = 1'b0;
        shift_s     = 1'b0;
        stop_s      = 1'b0;
        if (i_cs) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_CMD;
                    cnt_nxt_s   = 5'd0;
                end
                ST_CMD: begin
                    if (rise_s && bit_cnt_r == 5'd7) begin
                        cnt_nxt_s = 5'd0;
                        op_ld_s   = 1'b1;
                        case (rx_shift_s[7:0])
                            OP_READ, OP_WRITE: state_nxt_s = ST_ADDR;
                            OP_WRSR:           state_nxt_s = ST_SR_WR;
                            OP_RDSR:           state_nxt_s = ST_SR_RD;
                            default: begin
                                err_s       = 1'b1;
                                state_nxt_s = ST_DONE;
                            end
                        endcase
                    end else if (rise_s) begin
                        cnt_nxt_s = bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_ADDR: begin
                    if (rise_s && bit_cnt_r == 5'd15) begin
                        cnt_nxt_s   = 5'd0;
                        addr_ld_s   = 1'b1;
                        state_nxt_s = is_read_r ? ST_RDATA : ST_WDATA;
                    end else if (rise_s) begin
                        cnt_nxt_s = bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_WDATA: begin
                    if (rise_s && bit_cnt_r == 5'd7) begin
                        cnt_nxt_s   = 5'd0;
                        mem_we_s    = 1'b1;
                        addr_adv_s  = 1'b1;
                        state_nxt_s = byte_mode_s ? ST_DONE : ST_WDATA;
                    end else if (rise_s) begin
                        cnt_nxt_s = bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_RDATA: begin
                    // A fall at bit 0 starts a new byte; byte mode stops after one.
                    if (fall_s && bit_cnt_r == 5'd0) begin
                        if (byte_mode_s && byte_sent_r) begin
                            stop_s      = 1'b1;
                            state_nxt_s = ST_DONE;
                        end else begin
                            load_mem_s = 1'b1;
                            addr_adv_s = 1'b1;
                            cnt_nxt_s  = 5'd1;
                        end
                    end else if (fall_s) begin
                        shift_s   = 1'b1;
                        cnt_nxt_s = (bit_cnt_r == 5'd7) ? 5'd0 : bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_SR_WR: begin
                    if (rise_s && bit_cnt_r == 5'd7) begin
                        cnt_nxt_s   = 5'd0;
                        status_ld_s = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else if (rise_s) begin
                        cnt_nxt_s = bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_SR_RD: begin
                    if (fall_s && bit_cnt_r == 5'd0) begin
                        load_sr_s = 1'b1;
                        cnt_nxt_s = 5'd1;
                    end else if (fall_s) begin
                        shift_s   = 1'b1;
                        cnt_nxt_s = (bit_cnt_r == 5'd7) ? 5'd0 : bit_cnt_r + 5'd1;
                    end else begin
                        cnt_nxt_s = bit_cnt_r;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 5'd0;
                end
            endcase
        end
    end

    // Shift registers, address, status and registered pin outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_q_r     <= 1'b0;
            rx_r        <= 16'h0000;
            tx_r        <= 7'h00;
            addr_r      <= '0;
            is_read_r   <= 1'b0;
            byte_sent_r <= 1'b0;
            status_r    <= 8'h00;
            so_r        <= 1'b0;
            so_en_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            sck_q_r <= i_sck;
            err_r   <= err_s;
            if (rise_s) begin
                rx_r <= rx_shift_s;
            end
            if (op_ld_s) begin
                is_read_r <= (rx_shift_s[7:0] == OP_READ);
            end
            if (status_ld_s) begin
                status_r <= {rx_shift_s[7:6], 5'b00000, rx_shift_s[0]};
            end
            if (addr_ld_s) begin
                addr_r <= rx_shift_s[ADDR_W-1:0];
            end else if (addr_adv_s) begin
                addr_r <= addr_adv(addr_r, status_r[7:6]);
            end
            if (i_cs) begin
                so_r        <= 1'b0;
                so_en_r     <= 1'b0;
                byte_sent_r <= 1'b0;
            end else if (load_mem_s) begin
                tx_r        <= mem_rdata_s[6:0];
                so_r        <= mem_rdata_s[7];
                so_en_r     <= 1'b1;
                byte_sent_r <= 1'b1;
            end else if (load_sr_s) begin
                tx_r    <= status_r[6:0];
                so_r    <= status_r[7];
                so_en_r <= 1'b1;
            end else if (shift_s) begin
                tx_r <= {tx_r[5:0], 1'b0};
                so_r <= tx_r[6];
            end else if (stop_s) begin
                so_r    <= 1'b0;
                so_en_r <= 1'b0;
            end
        end
    end

    assign o_so     = so_r;
    assign o_so_en  = so_en_r;
    assign o_status = status_r;
    assign o_err    = err_r;

endmodule

// File: tb/tb_x_23k640_slave.sv
// Scoreboard bench for the 23K640 responder: directed SPI transactions, read bytes
// checked by an independent monitor against a queue of expected values.
module tb_x_23k640_slave;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cs = 1'b1;
    logic        i_sck = 1'b0;
    logic        i_si = 1'b0;
    logic        o_so, o_so_en, o_err;
    logic [7:0]  o_status;
    logic [12:0] i_bd_addr = 13'h0000;
    logic [7:0]  o_bd_rdata;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    logic [7:0] sb_q[$];

    x_23k640_slave #(.ADDR_W(13), .PAGE_W(5)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cs       (i_cs),
        .i_sck      (i_sck),
        .i_si       (i_si),
        .o_so       (o_so),
        .o_so_en    (o_so_en),
        .o_status   (o_status),
        .o_err      (o_err),
        .i_bd_addr  (i_bd_addr),
        .o_bd_rdata (o_bd_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One SPI byte (or its first nbits), mode 0: 3 low clocks, 2 high clocks per bit.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                        output logic en_any, output logic en_all);
        rx = 8'h00;
        en_any = 1'b0;
        en_all = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge i_clk);
            i_si = tx[i];
            @(negedge i_clk);
            @(negedge i_clk);
            rx[i]  = o_so;
            en_any = en_any | o_so_en;
            en_all = en_all & o_so_en;
            i_sck = 1'b1;
            @(negedge i_clk);
            @(negedge i_clk);
            i_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge i_clk);
        i_cs = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic cs_end();
        repeat (2) @(negedge i_clk);
        i_cs = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] rx;
        logic ea, el;
        xfer(b, 8, rx, ea, el);
    endtask

    task automatic wrsr(input logic [7:0] v);
        cs_begin();
        send(8'h01);
        send(v);
        cs_end();
    endtask

    task automatic wr2(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
        cs_begin();
        send(8'h02);
        send(a[15:8]);
        send(a[7:0]);
        send(d0);
        send(d1);
        cs_end();
    endtask

    task automatic bd(input logic [12:0] a, output logic [7:0] d);
        @(negedge i_clk);
        i_bd_addr = a;
        #1;
        d = o_bd_rdata;
    endtask

    // Monitor: assembles bytes the DUT drives and compares them to the scoreboard.
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] exp_b;
        int nb;
        nb = 0;
        sh = 8'h00;
        forever begin
            @(posedge i_sck or posedge i_cs);
            if (i_cs) begin
                nb = 0;
            end else if (o_so_en) begin
                sh = {sh[6:0], o_so};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got %0h want none", sh);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("sb_read", sh, exp_b);
                    end
                end
            end
        end
    end

    initial begin : err_mon
        forever begin
            @(negedge i_clk);
            if (o_err) err_cnt++;
        end
    end

    initial begin : stim
        logic [7:0] rx, d, old20, old11;
        logic ea, el;

        // Reset
        repeat (4) @(negedge i_clk);
        check("rst_so", o_so, 1'b0);
        check("rst_so_en", o_so_en, 1'b0);
        check("rst_status", o_status, 8'h00);
        check("rst_err", o_err, 1'b0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("post_rst_status", o_status, 8'h00);
        check("post_rst_so_en", o_so_en, 1'b0);

        // Config: WRSR then RDSR
        wrsr(8'h41);
        check("wrsr_status", o_status, 8'h41);
        cs_begin();
        xfer(8'h05, 8, rx, ea, el);
        check("rdsr_cmd_en_low", ea, 1'b0);
        sb_q.push_back(8'h41);
        xfer(8'h00, 8, rx, ea, el);
        check("rdsr_data_en_high", el, 1'b1);
        cs_end();
        check("rdsr_en_after_cs", o_so_en, 1'b0);

        // Sequential write / read / wrap
        wr2(16'h0002, 8'hA5, 8'h5A);
        bd(13'h0002, d); check("seq_wr_2", d, 8'hA5);
        bd(13'h0003, d); check("seq_wr_3", d, 8'h5A);
        cs_begin();
        send(8'h03); send(8'h00); send(8'h02);
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h5A);
        send(8'h00); send(8'h00);
        cs_end();
        wr2(16'h1FFF, 8'hC3, 8'h3C);
        bd(13'h1FFF, d); check("seq_wrap_1fff", d, 8'hC3);
        bd(13'h0000, d); check("seq_wrap_0000", d, 8'h3C);

        // Page mode
        wrsr(8'h81);
        check("page_status", o_status, 8'h81);
        bd(13'h0020, old20);
        wr2(16'h001F, 8'h11, 8'h22);
        bd(13'h001F, d); check("page_1f", d, 8'h11);
        bd(13'h0000, d); check("page_wrap_00", d, 8'h22);
        bd(13'h0020, d); check("page_20_kept", d, old20);

        // Byte mode
        wrsr(8'h00);
        check("byte_status", o_status, 8'h00);
        bd(13'h0011, old11);
        wr2(16'h0010, 8'h33, 8'h44);
        bd(13'h0010, d); check("byte_wr_10", d, 8'h33);
        bd(13'h0011, d); check("byte_11_kept", d, old11);
        cs_begin();
        send(8'h03); send(8'h00); send(8'h10);
        sb_q.push_back(8'h33);
        send(8'h00);
        xfer(8'h00, 8, rx, ea, el);
        check("byte_rd_tail_so", rx, 8'h00);
        check("byte_rd_tail_en", ea, 1'b0);
        cs_end();

        // Abort after 4 data bits
        wr2(16'h0040, 8'h5C, 8'h00);
        bd(13'h0040, d); check("abort_pre", d, 8'h5C);
        cs_begin();
        send(8'h02); send(8'h00); send(8'h40);
        xfer(8'hFF, 4, rx, ea, el);
        cs_end();
        bd(13'h0040, d); check("abort_kept", d, 8'h5C);

        // Illegal opcode, then a normal transaction
        check("err_none_yet", err_cnt, 0);
        cs_begin();
        xfer(8'hFF, 8, rx, ea, el);
        check("ill_cmd_en", ea, 1'b0);
        xfer(8'h00, 8, rx, ea, el);
        check("ill_data_en", ea, 1'b0);
        cs_end();
        check("ill_err_pulse", err_cnt, 1);
        wrsr(8'h41);
        check("ill_next_status", o_status, 8'h41);
        cs_begin();
        send(8'h03); send(8'h00); send(8'h02);
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h5A);
        send(8'h00); send(8'h00);
        cs_end();
        check("ill_err_single", err_cnt, 1);

        repeat (5) @(negedge i_clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
